demux_1_4_buffered: RTL
=======================

# demux_1_4_buffered

Registered 1-to-4 demultiplexer: routes one WIDTH-bit word per handshake from a single producer to one of four consumer channels chosen by a 2-bit select. Each output channel has a one-entry holding register with valid/ready flow control, so a stalled consumer blocks only traffic addressed to it. It is the distribution side of the datapath's 4-to-1 selection muxes, fanning one result bus out to four independent destinations. It also keeps a wrap-around count of accepted words.

## Interface
- WIDTH, 32, data width of input and each output channel
- CNT_WIDTH, 16, width of accept_count
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  producer presents a word
- in_ready  output  1  block can accept the word addressed by select this cycle
- select  input  2  destination channel, 0..3 (all four codes valid)
- in_data  input  WIDTH  word to route
- out_valid  output  4  bit k: channel k holding register full
- out_ready  input  4  bit k: consumer k takes the word this cycle
- output0..output3  output  WIDTH each  holding-register contents of channels 0..3
- accept_count  output  CNT_WIDTH  number of accepted input words, modulo 2^CNT_WIDTH

## Operation
- Per channel k: state full[k] (EMPTY/FULL), data register buf[k]; out_valid[k] = full[k], outputK = buf[k].
- in_ready = !full[select] | out_ready[select] (combinational from select, full, out_ready; no dependence on in_valid).
- Accept = in_valid & in_ready. On accept: buf[select] <= in_data, full[select] <= 1, accept_count <= accept_count + 1.
- Drain of channel k = full[k] & out_ready[k]. Drain with no accept to k: full[k] <= 0, buf[k] holds its value.
- Drain and accept to the same channel in one cycle: full[k] stays 1, buf[k] replaced by the new word (no bubble).
- Accept to channel j and drains on other channels in the same cycle are independent; all take effect.
- in_valid with in_ready low: nothing changes; producer must hold select and in_data stable until accepted.
- A consumer may drop out_ready at any time; a full channel keeps out_valid and data stable until drained.
- out_ready on an empty channel has no effect.
- Channel transitions: EMPTY -> FULL on accept; FULL -> EMPTY on drain without accept; FULL -> FULL on accept with simultaneous drain or on no drain.
- accept_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Per-channel order is preserved; no ordering between channels.

## Timing
- Reset (rst_n low, asynchronous, any time including mid-transfer): full = 0 on all channels, out_valid = 4'b0000, output0..3 = 0, accept_count = 0; a word in flight is discarded. in_ready = 1 while in reset (all channels empty). First accept possible on first rising edge after rst_n deasserts.
- Latency: word accepted at edge N appears on outputK with out_valid[k] = 1 right after edge N; earliest consumer handshake is at edge N+1.
- Throughput: one word per cycle sustained to one channel while its out_ready is held 1; one word per cycle total across channels.
- in_ready, out_valid and outputs settle within the same cycle; only in_ready has a combinational path (from out_ready and select).

## Test plan
- Reset: assert rst_n = 0 mid-stream with channel 2 full -> out_valid = 0000, output2 = 0, accept_count = 0, in_ready = 1 immediately, before any clock edge.
- Basic route: select = 1, in_data = 0xDEADBEEF, out_ready = 0000 -> after edge out_valid = 0010, output1 = 0xDEADBEEF, accept_count = 1; other outputs stay 0.
- Back-pressure: channel 3 full, out_ready[3] = 0, in_valid = 1, select = 3 -> in_ready = 0, output3 unchanged; same cycle select = 0 -> in_ready = 1 and word lands in channel 0.
- Pass-through: channel 2 full with 0x11, out_ready[2] = 1, in_valid = 1, select = 2, in_data = 0x22 -> in_ready = 1, after edge out_valid[2] = 1, output2 = 0x22; 8-word burst completes in 8 cycles.
- Concurrent: channels 0 and 1 full, out_ready = 0011, accept to select = 3 -> after edge out_valid = 1000, output3 = new word.
- Counter wrap: preload via 65535 accepts, one more accept -> accept_count = 0.

Source files
------------

// File: rtl/demux_1_4_buffered_if.sv
// demux_1_4_buffered_if: producer and four-consumer bus of the buffered 1-to-4 demux.
interface demux_1_4_buffered_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           select;
    logic [WIDTH-1:0]     in_data;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic [WIDTH-1:0]     output0;
    logic [WIDTH-1:0]     output1;
    logic [WIDTH-1:0]     output2;
    logic [WIDTH-1:0]     output3;
    logic [CNT_WIDTH-1:0] accept_count;

    modport master (
        output in_valid, select, in_data, out_ready,
        input  in_ready, out_valid, output0, output1, output2, output3, accept_count
    );

    modport slave (
        input  in_valid, select, in_data, out_ready,
        output in_ready, out_valid, output0, output1, output2, output3, accept_count
    );
endinterface

// File: rtl/demux_1_4_buffered.sv
// demux_1_4_buffered: routes one word per handshake to one of four channels,
// each with a one-entry holding register, and counts accepted words.
module demux_1_4_buffered #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux_1_4_buffered_if.slave   bus
);
    typedef enum logic {EMPTY, FULL} ch_state_t;

    logic [3:0]           w_full;
    logic                 w_accept;
    logic [CNT_WIDTH-1:0] r_count;

    // A full channel can still accept when its consumer drains in the same cycle.
    assign bus.in_ready = !w_full[bus.select] | bus.out_ready[bus.select];
    assign w_accept     = bus.in_valid & bus.in_ready;

    for (genvar g = 0; g < 4; g++) begin : ch
        ch_state_t        r_state;
        ch_state_t        w_state_nxt;
        logic [WIDTH-1:0] r_buf;
        logic             w_hit;

        assign w_full[g] = (r_state == FULL);
        assign w_hit     = w_accept && (bus.select == 2'(g));

        always_comb begin
            w_state_nxt = r_state;
            if (w_hit)
                w_state_nxt = FULL;
            else if (w_full[g] && bus.out_ready[g])
                w_state_nxt = EMPTY;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= EMPTY;
                r_buf   <= '0;
            end else begin
                r_state <= w_state_nxt;
                if (w_hit)
                    r_buf <= bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (w_accept)
            r_count <= r_count + 1'b1;
    end

    assign bus.out_valid    = w_full;
    assign bus.output0      = ch[0].r_buf;
    assign bus.output1      = ch[1].r_buf;
    assign bus.output2      = ch[2].r_buf;
    assign bus.output3      = ch[3].r_buf;
    assign bus.accept_count = r_count;
endmodule
